mem_responder: RTL and testbench

- Responder (memory side) for the CPU's split instruction/data memory interface: serves `i_readM`/`i_address`/`i_data` and `d_readM`/`d_writeM`/`d_address`/`d_data` from one shared word array.
- Adds a fixed, parameterised response latency with a per-port ready pulse, so the pipeline can be exercised against stalling memory ahead of the cache work.
- Replaces the zero-latency behavioural memory in the testbench.

---
 rtl/mem_responder_pkg.sv | 13 +
 rtl/mem_responder_port_fsm.sv | 102 ++++++++++
 rtl/mem_responder.sv | 93 +++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for the latency-adding memory responder: per-port FSM
// state encodings and the default response latency.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  localparam int MEM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_responder_port_fsm.sv
// One memory port: accepts a request in IDLE, counts out the latency, then
// holds a single RESP cycle. Reports the edge on which RESP is entered.
import mem_responder_pkg::*;

module mem_port_fsm #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = MEM_DEFAULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_rd,
  input  logic                 req_wr,
  input  logic [ADDR_BITS-1:0] req_idx,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 ready,
  output logic                 rd_oe,
  output logic                 commit,
  output logic [ADDR_BITS-1:0] commit_idx,
  output logic                 commit_wr,
  output logic [WORD_SIZE-1:0] commit_wdata,
  output logic                 proto_err,
  output mem_state_e           state
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   enter_resp;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (req_rd || req_wr) begin
          // Read+write together resolves to a write and flags the initiator.
          idx_d   = req_idx;
          wr_d    = req_wr;
          wdata_d = req_wdata;
          err_d   = err_q | (req_rd & req_wr);
          cnt_d   = CNT_INIT;
          if (CNT_INIT == 4'd0) begin
            state_d    = MEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = MEM_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // The _d copies carry the live request when RESP is entered straight from IDLE.
  assign commit       = enter_resp;
  assign commit_idx   = idx_d;
  assign commit_wr    = wr_d;
  assign commit_wdata = wdata_d;
  assign ready        = (state_q == MEM_RESP);
  assign rd_oe        = (state_q == MEM_RESP) && !wr_q;
  assign proto_err    = err_q;
  assign state        = state_q;

endmodule

// File: rtl/mem_responder.sv
// Shared-array memory responder for the split I/D CPU interface with a fixed
// response latency, per-port ready pulses and a testbench preload port.
import mem_responder_pkg::*;

module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = MEM_DEFAULT_LATENCY
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 proto_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 i_oe, i_commit, i_cwr, i_perr;
  logic [ADDR_BITS-1:0] i_cidx;
  logic [WORD_SIZE-1:0] i_cwdata;
  mem_state_e           i_state;
  logic                 d_oe, d_commit, d_cwr;
  logic [ADDR_BITS-1:0] d_cidx;
  logic [WORD_SIZE-1:0] d_cwdata;
  mem_state_e           d_state;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                 unused_sig;

  mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_i_port (
    .clk(Clk), .rst_n(Reset_N),
    .req_rd(i_readM), .req_wr(1'b0),
    .req_idx(i_address[ADDR_BITS-1:0]), .req_wdata('0),
    .ready(i_ready), .rd_oe(i_oe), .commit(i_commit),
    .commit_idx(i_cidx), .commit_wr(i_cwr), .commit_wdata(i_cwdata),
    .proto_err(i_perr), .state(i_state)
  );

  mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_d_port (
    .clk(Clk), .rst_n(Reset_N),
    .req_rd(d_readM), .req_wr(d_writeM),
    .req_idx(d_address[ADDR_BITS-1:0]), .req_wdata(d_data),
    .ready(d_ready), .rd_oe(d_oe), .commit(d_commit),
    .commit_idx(d_cidx), .commit_wr(d_cwr), .commit_wdata(d_cwdata),
    .proto_err(proto_err), .state(d_state)
  );

  // Captures read the array before this edge's writes land (read-before-write).
  always_comb begin
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (i_commit && !i_cwr) i_rdata_d = mem[i_cidx];
    if (d_commit && !d_cwr) d_rdata_d = mem[d_cidx];
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Contents survive reset; reset only blocks writes. Preload is last so it wins.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
    end else begin
      if (d_commit && d_cwr) mem[d_cidx] <= d_cwdata;
      if (load_en)           mem[load_addr] <= load_data;
    end
  end

  assign i_data = i_oe ? i_rdata_q : {WORD_SIZE{1'bz}};
  assign d_data = d_oe ? d_rdata_q : {WORD_SIZE{1'bz}};

  assign unused_sig = ^{i_writeM, i_address, d_address, i_cwdata, i_perr, i_state, d_state};

endmodule

// File: tb/tb_mem_responder.sv
// Directed checks of mem_responder: latency, aliasing, collisions, protocol
// error, reset behaviour and back-to-back requests at LATENCY=1.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        i_readM = 1'b0, i_writeM = 1'b0;
  logic [15:0] i_address = '0;
  wire  [15:0] i_data;
  logic        i_ready;
  logic        d_readM = 1'b0, d_writeM = 1'b0;
  logic [15:0] d_address = '0;
  wire  [15:0] d_data;
  logic        d_ready;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        proto_err;
  logic        tb_d_oe = 1'b0;
  logic [15:0] tb_d_val = '0;

  logic        d1_readM = 1'b0;
  logic [15:0] d1_address = '0;
  wire  [15:0] i1_data, d1_data;
  logic        i1_ready, d1_ready, p1_err;
  logic        l1_en = 1'b0;
  logic [7:0]  l1_addr = '0;
  logic [15:0] l1_data = '0;

  int checks = 0;
  int errors = 0;

  assign d_data = tb_d_oe ? tb_d_val : 16'hzzzz;

  always #5 Clk = ~Clk;

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data), .d_ready(d_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .proto_err(proto_err)
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut1 (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_readM(1'b0), .i_writeM(1'b0), .i_address(16'h0000), .i_data(i1_data), .i_ready(i1_ready),
    .d_readM(d1_readM), .d_writeM(1'b0), .d_address(d1_address), .d_data(d1_data), .d_ready(d1_ready),
    .load_en(l1_en), .load_addr(l1_addr), .load_data(l1_data), .proto_err(p1_err)
  );

  task automatic load_word(input logic [7:0] a, input logic [15:0] v);
    @(negedge Clk);
    load_en = 1'b1; load_addr = a; load_data = v;
    @(negedge Clk);
    load_en = 1'b0;
  endtask

  // Drives one D transaction; cyc is the cycle index of d_ready (0 = timed out).
  task automatic d_access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata,
                          output int cyc, output logic oe_seen);
    @(negedge Clk);
    d_readM = rd; d_writeM = wr; d_address = addr; tb_d_val = wdata; tb_d_oe = wr;
    cyc = 0; rdata = '0; oe_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (d_ready) begin
        cyc = k; rdata = d_data; oe_seen = dut.d_oe;
        break;
      end
    end
    d_readM = 1'b0; d_writeM = 1'b0; tb_d_oe = 1'b0;
  endtask

  task automatic i_access(input logic [15:0] addr, output logic [15:0] rdata, output int cyc);
    @(negedge Clk);
    i_readM = 1'b1; i_address = addr;
    cyc = 0; rdata = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (i_ready) begin
        cyc = k; rdata = i_data;
        break;
      end
    end
    i_readM = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clk);
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    checks++; if (dut.i_oe !== 1'b0 || dut.d_oe !== 1'b0) begin errors++; $display("FAIL reset_bus_drive: i_oe %b d_oe %b want 0 0", dut.i_oe, dut.d_oe); end
    checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL reset_d1_ready: got %b want 0", d1_ready); end
    Reset_N = 1'b1;
  endtask

  task automatic test_i_read;
    logic exp;
    load_word(8'd5, 16'hA5A5);
    @(negedge Clk);
    checks++; if (dut.i_oe !== 1'b0) begin errors++; $display("FAIL i_read_idle_bus: oe %b want 0", dut.i_oe); end
    i_readM = 1'b1; i_address = 16'd5;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      exp = (k == 3);
      checks++; if (i_ready !== exp) begin errors++; $display("FAIL i_read_ready_c%0d: got %b want %b", k, i_ready, exp); end
      checks++; if (dut.i_oe !== exp) begin errors++; $display("FAIL i_read_oe_c%0d: got %b want %b", k, dut.i_oe, exp); end
      if (k == 3) begin
        checks++; if (i_data !== 16'hA5A5) begin errors++; $display("FAIL i_read_data: got %h want a5a5", i_data); end
        i_readM = 1'b0;
      end
    end
  endtask

  task automatic test_d_alias;
    logic [15:0] rd; int cyc; logic oe;
    d_access(1'b0, 1'b1, 16'h0105, 16'h1234, rd, cyc, oe);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL d_write_latency: got %0d want 3", cyc); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL d_write_bus_z: oe %b want 0", oe); end
    d_access(1'b1, 1'b0, 16'h0005, 16'h0000, rd, cyc, oe);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL d_read_latency: got %0d want 3", cyc); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL d_read_bus_drive: oe %b want 1", oe); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL d_alias_data: got %h want 1234", rd); end
  endtask

  task automatic test_collision;
    logic [15:0] rd; int cyc;
    load_word(8'd7, 16'h0001);
    @(negedge Clk);
    i_readM = 1'b1; i_address = 16'd7;
    d_writeM = 1'b1; d_address = 16'd7; tb_d_val = 16'h00FF; tb_d_oe = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (i_ready !== 1'b1 || d_ready !== 1'b1) begin errors++; $display("FAIL collide_ready: i %b d %b want 1 1", i_ready, d_ready); end
    checks++; if (i_data !== 16'h0001) begin errors++; $display("FAIL collide_old_data: got %h want 0001", i_data); end
    i_readM = 1'b0; d_writeM = 1'b0; tb_d_oe = 1'b0;
    i_access(16'd7, rd, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL collide_reread_latency: got %0d want 3", cyc); end
    checks++; if (rd !== 16'h00FF) begin errors++; $display("FAIL collide_new_data: got %h want 00ff", rd); end
  endtask

  task automatic test_proto;
    logic [15:0] rd; int cyc; logic oe;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_before: got %b want 0", proto_err); end
    d_access(1'b1, 1'b1, 16'd9, 16'hBEEF, rd, cyc, oe);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL proto_as_write_bus: oe %b want 0", oe); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b want 1", proto_err); end
    repeat (10) @(negedge Clk);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
    d_access(1'b1, 1'b0, 16'd9, 16'h0000, rd, cyc, oe);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL proto_write_data: got %h want beef", rd); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; int cyc; logic oe;
    load_word(8'd3, 16'h0000);
    load_word(8'd4, 16'h4444);
    @(negedge Clk);
    d_writeM = 1'b1; d_address = 16'd3; tb_d_val = 16'hDEAD; tb_d_oe = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_N = 1'b0;
    d_writeM = 1'b0; tb_d_oe = 1'b0;
    load_en = 1'b1; load_addr = 8'd4; load_data = 16'hFFFF;
    #1;
    checks++; if (d_ready !== 1'b0 || i_ready !== 1'b0) begin errors++; $display("FAIL rst_wait_ready: d %b i %b want 0 0", d_ready, i_ready); end
    checks++; if (dut.d_oe !== 1'b0 || dut.i_oe !== 1'b0) begin errors++; $display("FAIL rst_wait_bus: d_oe %b i_oe %b want 0 0", dut.d_oe, dut.i_oe); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_clear: got %b want 0", proto_err); end
    repeat (2) @(negedge Clk);
    load_en = 1'b0;
    Reset_N = 1'b1;
    d_access(1'b1, 1'b0, 16'd3, 16'h0000, rd, cyc, oe);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_write_dropped: got %h want 0000", rd); end
    d_access(1'b1, 1'b0, 16'd4, 16'h0000, rd, cyc, oe);
    checks++; if (rd !== 16'h4444) begin errors++; $display("FAIL rst_load_blocked: got %h want 4444", rd); end
    d_access(1'b1, 1'b0, 16'd5, 16'h0000, rd, cyc, oe);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rst_contents_kept: got %h want 1234", rd); end
    @(negedge Clk);
    i_readM = 1'b1; i_address = 16'd5;
    repeat (3) @(negedge Clk);
    checks++; if (dut.i_oe !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: oe %b want 1", dut.i_oe); end
    Reset_N = 1'b0;
    i_readM = 1'b0;
    #1;
    checks++; if (dut.i_oe !== 1'b0 || i_ready !== 1'b0) begin errors++; $display("FAIL rst_resp_release: oe %b ready %b want 0 0", dut.i_oe, i_ready); end
    @(negedge Clk);
    Reset_N = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic exp; int pulses;
    pulses = 0;
    @(negedge Clk);
    l1_en = 1'b1; l1_addr = 8'd2; l1_data = 16'h2222;
    @(negedge Clk);
    l1_en = 1'b0;
    d1_readM = 1'b1; d1_address = 16'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      exp = (k % 2 == 1);
      checks++; if (d1_ready !== exp) begin errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", k, d1_ready, exp); end
      if (d1_ready) begin
        pulses++;
        checks++; if (d1_data !== 16'h2222) begin errors++; $display("FAIL b2b_data_c%0d: got %h want 2222", k, d1_data); end
      end
    end
    d1_readM = 1'b0;
    checks++; if (pulses !== 6) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 6", pulses); end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_alias();
    test_collision();
    test_proto();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
